// File: rtl/barrel_shift_arb.sv
// Two-requester front end for one shared 8-bit barrel shifter: round-robin grant,
// multi-pass execution of shift amounts above STEP_MAX, result held until taken.
module barrel_shift_arb #(
    parameter int WIDTH    = 8,
    parameter int AMT_W    = 4,
    parameter int STEP_MAX = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_data,
    input  logic             req0_lr,
    input  logic [AMT_W-1:0] req0_n,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_data,
    input  logic             req1_lr,
    input  logic [AMT_W-1:0] req1_n,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_id,
    output logic             busy
);

    localparam int STEP_W = $clog2(STEP_MAX + 1);
    localparam logic [AMT_W-1:0] STEP_LIM = AMT_W'(STEP_MAX);

    typedef enum logic [1:0] {IDLE, SHIFT, RESP} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] acc_q;
    logic             lr_q;
    logic [AMT_W-1:0] rem_q;
    logic             id_q;
    logic             last_q;
    logic             rsp_valid_q;
    logic [WIDTH-1:0] rsp_data_q;
    logic             rsp_id_q;
    logic             busy_q;

    logic             gnt_vld_d;
    logic             gnt_id_d;
    logic [AMT_W-1:0] step_d;
    logic [AMT_W-1:0] rem_d;
    logic [WIDTH-1:0] shift_d;

    function automatic logic [WIDTH-1:0] shift_pass(input logic [WIDTH-1:0] v,
                                                    input logic              left,
                                                    input logic [STEP_W-1:0] s);
        return left ? (v << s) : (v >> s);
    endfunction

    always_comb begin
        gnt_vld_d = 1'b0;
        gnt_id_d  = 1'b0;
        if (state_q == IDLE) begin
            if (req0_valid && req1_valid) begin
                gnt_vld_d = 1'b1;
                gnt_id_d  = ~last_q;
            end else if (req0_valid) begin
                gnt_vld_d = 1'b1;
            end else if (req1_valid) begin
                gnt_vld_d = 1'b1;
                gnt_id_d  = 1'b1;
            end
        end
    end

    // Readies are combinational; gating with rst_n keeps them low while reset is asserted.
    assign req0_ready = rst_n && gnt_vld_d && !gnt_id_d;
    assign req1_ready = rst_n && gnt_vld_d && gnt_id_d;

    always_comb begin
        step_d  = (rem_q > STEP_LIM) ? STEP_LIM : rem_q;
        rem_d   = rem_q - step_d;
        shift_d = shift_pass(acc_q, lr_q, step_d[STEP_W-1:0]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            lr_q        <= 1'b0;
            rem_q       <= '0;
            id_q        <= 1'b0;
            last_q      <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (gnt_vld_d) begin
                        acc_q   <= gnt_id_d ? req1_data : req0_data;
                        lr_q    <= gnt_id_d ? req1_lr : req0_lr;
                        rem_q   <= gnt_id_d ? req1_n : req0_n;
                        id_q    <= gnt_id_d;
                        last_q  <= gnt_id_d;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    acc_q <= shift_d;
                    rem_q <= rem_d;
                    if (rem_d == '0) begin
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= shift_d;
                        rsp_id_q    <= id_q;
                        state_q     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_barrel_shift_arb.sv
// Randomized bench for barrel_shift_arb against an arithmetic reference model
// (whole-word shift of the original amount, round-robin grant by last winner).
module tb_barrel_shift_arb;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0_valid, req0_ready, req0_lr;
    logic [7:0] req0_data;
    logic [3:0] req0_n;
    logic       req1_valid, req1_ready, req1_lr;
    logic [7:0] req1_data;
    logic [3:0] req1_n;
    logic       rsp_valid, rsp_ready, rsp_id, busy;
    logic [7:0] rsp_data;

    int total = 0;
    int bad   = 0;

    logic [7:0] d [2];
    logic       lr[2];
    logic [3:0] n [2];
    logic       v [2];
    int         last_g;

    always #5 clk = ~clk;

    barrel_shift_arb dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req0_valid(req0_valid),
        .req0_ready(req0_ready),
        .req0_data (req0_data),
        .req0_lr   (req0_lr),
        .req0_n    (req0_n),
        .req1_valid(req1_valid),
        .req1_ready(req1_ready),
        .req1_data (req1_data),
        .req1_lr   (req1_lr),
        .req1_n    (req1_n),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive();
        req0_valid = v[0]; req0_data = d[0]; req0_lr = lr[0]; req0_n = n[0];
        req1_valid = v[1]; req1_data = d[1]; req1_lr = lr[1]; req1_n = n[1];
    endtask

    task automatic new_cmd(input int i);
        v[i]  = 1'b1;
        d[i]  = 8'($urandom);
        lr[i] = 1'($urandom);
        n[i]  = 4'($urandom);
    endtask

    // Called one step after a rising edge with the DUT idle; bp = cycles of rsp backpressure.
    task automatic do_txn(input int bp);
        int          g, ep, cnt;
        logic [31:0] t;
        logic [7:0]  ed;
        drive();
        #1;
        g = (v[0] && v[1]) ? (1 - last_g) : (v[0] ? 0 : 1);
        chk("ready0", req0_ready, g == 0);
        chk("ready1", req1_ready, g == 1);
        t  = {24'd0, d[g]};
        t  = lr[g] ? (t << n[g]) : (t >> n[g]);
        ed = t[7:0];
        ep = (n[g] == 0) ? 1 : (int'(n[g]) + 6) / 7;
        last_g = g;
        @(posedge clk); #1;
        // Granted requester withdraws and scribbles its inputs; the command must already be captured.
        v[g] = 1'b0; d[g] = 8'($urandom); lr[g] = 1'($urandom); n[g] = 4'($urandom);
        drive();
        cnt = 0;
        while (!rsp_valid && cnt < 8) begin
            chk("shift_busy", busy, 1);
            chk("shift_rdy", {req0_ready, req1_ready}, 0);
            @(posedge clk); #1;
            cnt++;
        end
        chk("passes", cnt, ep);
        chk("rsp_data", rsp_data, ed);
        chk("rsp_id", rsp_id, g);
        chk("rsp_busy", busy, 1);
        repeat (bp) begin
            rsp_ready = 1'b0;
            @(posedge clk); #1;
            chk("bp_valid", rsp_valid, 1);
            chk("bp_data", rsp_data, ed);
            chk("bp_id", rsp_id, g);
            chk("bp_rdy", {req0_ready, req1_ready}, 0);
            chk("bp_busy", busy, 1);
        end
        rsp_ready = 1'b1;
        #1;
        chk("hs_rdy", {req0_ready, req1_ready}, 0);
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("post_valid", rsp_valid, 0);
        chk("post_busy", busy, 0);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            v[i] = 1'b0; d[i] = '0; lr[i] = 1'b0; n[i] = '0;
        end
        drive();
        rsp_ready = 1'b0;
        rst_n     = 1'b0;
        last_g    = 1;
        #3;
        chk("rst_out", {req0_ready, req1_ready, rsp_valid, busy, rsp_id}, 0);
        chk("rst_data", rsp_data, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_out", {req0_ready, req1_ready, rsp_valid, busy}, 0);

        // Directed commands
        v[0] = 1; d[0] = 8'hB5; lr[0] = 1; n[0] = 4'd3;
        do_txn(0);
        v[1] = 1; d[1] = 8'h80; lr[1] = 0; n[1] = 4'd7;
        do_txn(0);
        v[1] = 1; d[1] = 8'hFF; lr[1] = 1; n[1] = 4'd15;
        do_txn(0);
        v[0] = 1; d[0] = 8'h3C; lr[0] = 1'($urandom); n[0] = 4'd0;
        do_txn(0);
        v[0] = 1; d[0] = 8'h96; lr[0] = 0; n[0] = 4'd9;
        do_txn(5);

        // Continuous contention: the waiting requester keeps its command
        new_cmd(0); new_cmd(1);
        repeat (4) begin
            do_txn(int'($urandom_range(0, 2)));
            new_cmd(last_g);
        end
        v[0] = 0; v[1] = 0; drive();

        // Asynchronous reset in the middle of a three-pass command
        v[0] = 1; d[0] = 8'hFF; lr[0] = 1; n[0] = 4'd15; v[1] = 0;
        drive(); #1;
        chk("mr_rdy0", req0_ready, 1);
        @(posedge clk); #1;
        v[0] = 0; v[1] = 1; d[1] = 8'h81; lr[1] = 1; n[1] = 4'd1;
        drive();
        @(posedge clk); #1;
        chk("mr_busy", busy, 1);
        chk("mr_valid", rsp_valid, 0);
        v[0] = 1; d[0] = 8'h5A; lr[0] = 0; n[0] = 4'd2;
        drive();
        #2 rst_n = 1'b0;
        #1;
        chk("mr_out", {req0_ready, req1_ready, rsp_valid, busy, rsp_id}, 0);
        chk("mr_data", rsp_data, 0);
        last_g = 1;
        @(posedge clk); #1;
        chk("mr_hold", {req0_ready, req1_ready, rsp_valid, busy}, 0);
        rst_n = 1'b1;
        #1;
        chk("mr_norsp", rsp_valid, 0);
        chk("mr_tie0", req0_ready, 1);
        do_txn(1);
        new_cmd(0);
        do_txn(0);

        // Random traffic
        v[0] = 0; v[1] = 0;
        repeat (40) begin
            for (int i = 0; i < 2; i++)
                if (!v[i] && ($urandom_range(0, 3) != 0)) new_cmd(i);
            if (!v[0] && !v[1]) new_cmd(int'($urandom_range(0, 1)));
            do_txn(int'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
